pkt_rr_arbiter: RTL and testbench
=================================

Name: pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_PORTS translated packet streams onto one 64-bit egress bus.
- Each input is the output side of a packet translator (valid/sop/eop/plen/bad/half-word qualifiers).
- The grant is held from sop to eop, so packets never interleave.
- Includes a registered egress stage, protocol checking, a stall watchdog that closes stuck packets, and a sticky CPU interrupt.

Parameters:
- NUM_PORTS, 4, number of requesting streams (2..8).
- DATA_WIDTH, 64, beat width.
- PLEN_WIDTH, 14, packet length field width (bytes).
- TIMEOUT_CYCLES, 1024, idle cycles mid-packet before abort (>=2).

Ports:
- iclk  in  1  single clock.
- irst_n  in  1  asynchronous active-low reset.
- ivalid  in  NUM_PORTS  per-port beat valid.
- isop  in  NUM_PORTS  per-port start of packet.
- ieop  in  NUM_PORTS  per-port end of packet.
- ibad  in  NUM_PORTS  per-port bad-packet flag.
- ihalf_word_valid  in  NUM_PORTS  per-port: only upper 32 bits valid on eop beat.
- idata  in  NUM_PORTS*DATA_WIDTH  flattened beats; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- iplen  in  NUM_PORTS*PLEN_WIDTH  flattened packet lengths.
- iready  out  NUM_PORTS  per-port ready.
- ovalid  out  1  egress beat valid.
- osop  out  1  egress start of packet.
- oeop  out  1  egress end of packet.
- obad  out  1  egress bad flag.
- ohalf_word_valid  out  1  egress half-word qualifier.
- odata  out  DATA_WIDTH  egress data.
- oplen  out  PLEN_WIDTH  egress packet length.
- oport_id  out  $clog2(NUM_PORTS)  source port of current egress beat.
- oready  in  1  egress ready.
- oerr_status  out  3  sticky errors: [0] missing sop, [1] unexpected mid-packet sop, [2] timeout.
- ocpu_interrupt  out  1  OR of oerr_status.

Behaviour:
- Reset is asynchronous and active-low: irst_n low forces IDLE, all outputs 0, last-grant pointer = NUM_PORTS-1 (port 0 wins first), watchdog 0, oerr_status 0.
- Deasserting irst_n mid-packet or mid-operation is not special-cased; all state simply restarts from reset values.
- Transfers follow valid/ready rules:
  - Egress beat transfers when ovalid & oready.
  - Ingress beat transfers when ivalid[g] & iready[g].
  - Internal accept signal acc = ~ovalid | oready.
- Egress register loads on any forwarded ingress transfer. When acc holds and nothing is forwarded, it clears ovalid.
- States: IDLE, PKT, DROP, ABORT.
- IDLE: iready = 0 on all ports.
  - If any ivalid is set, pick the first requesting port strictly after the last-grant pointer, wrapping modulo NUM_PORTS.
  - Register the pick as grant g, update the pointer, go to PKT.
  - No request: stay in IDLE.
- PKT: iready[g] = acc; all other iready = 0.
  - First beat of the packet without isop: drop it (consume, do not forward), set err[0]. If that beat has no ieop go to DROP, otherwise go to IDLE.
  - Later beat with isop: set err[1]; forward the beat with osop forced to 0.
  - Every forwarded beat copies eop/bad/half_word_valid/data/plen from port g; oport_id = g.
  - eop beat transferred: go to IDLE. This leaves a one-cycle bubble between packets, which is accepted.
- DROP: iready[g] = 1; beats are discarded. Go to IDLE on transfer of an eop beat.
- Watchdog: runs only in PKT.
  - Counts cycles with ivalid[g] = 0; clears on any port-g transfer and on entering PKT.
  - Count reaching TIMEOUT_CYCLES-1: set err[2], go to ABORT.
- ABORT: iready = 0 on all ports.
  - When acc, load a synthetic beat: ovalid = 1, oeop = 1, obad = 1, osop = 0, odata = 0, ohalf_word_valid = 0, oplen = 0, oport_id = g. Then go to DROP.
- Simultaneous events: eop transfer and watchdog expiry in the same cycle resolve as eop (a transfer clears the watchdog).
- Latency: input sop present with the bus idle and oready = 1 gives osop 2 cycles later (1 arbitration + 1 egress register). Throughput within a packet is 1 beat/cycle.
- oerr_status bits are sticky until reset.

Decomposition:
- Package pkt_arb_pkg:
  - state_t enum {IDLE, PKT, DROP, ABORT}.
  - Error-bit index constants ERR_NO_SOP = 0, ERR_MID_SOP = 1, ERR_TIMEOUT = 2.
  - Packed beat_t struct {sop, eop, bad, half_word_valid, plen, data}.
- Sub-module rr_picker: combinational round-robin select. Inputs are the request vector and the pointer; outputs are grant index and any-request.

Test Plan:
- Ports 0 and 2 each send a 3-beat packet starting in the same cycle, oready = 1 -> port 0 packet exits first (osop at cycle +2), then one bubble, then port 2. Both carry the correct oport_id and unchanged odata/oplen.
- All 4 ports continuously requesting, 8 packets -> grant order 0,1,2,3,0,1,2,3, with no interleaving between sop and eop.
- oready toggled 0/1 every cycle during a 4-beat packet -> no beat lost or duplicated, and odata stays stable while ovalid & ~oready.
- Port 1 sends a first beat with isop = 0, then 2 more beats ending in eop -> nothing forwarded, oerr_status = 3'b001, ocpu_interrupt = 1, and arbitration resumes afterward.
- TIMEOUT_CYCLES = 16; port 3 sends sop then stalls 16 cycles -> one beat with oeop = 1, obad = 1, odata = 0; oerr_status[2] = 1; port 3's later beats are dropped through its eop.
- irst_n pulsed low mid-packet -> all outputs 0 immediately, and the next arbitration grants port 0.

Source files
------------

// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types for the packet round-robin arbiter: FSM states, error bit
// positions and the beat held in the egress register.
package pkt_arb_pkg;

   typedef enum logic [1:0] {IDLE, PKT, DROP, ABORT} state_t;

   localparam int ERR_NO_SOP  = 0;
   localparam int ERR_MID_SOP = 1;
   localparam int ERR_TIMEOUT = 2;

   // Beat field widths; the top-level DATA_WIDTH / PLEN_WIDTH track these.
   localparam int BEAT_DATA_W = 64;
   localparam int BEAT_PLEN_W = 14;

   typedef struct packed {
      logic                   sop;
      logic                   eop;
      logic                   bad;
      logic                   half_word_valid;
      logic [BEAT_PLEN_W-1:0] plen;
      logic [BEAT_DATA_W-1:0] data;
   } beat_t;

endpackage

// File: rtl/pkt_rr_arbiter_picker.sv
// Combinational round-robin pick: first requester strictly after ptr,
// wrapping modulo N.
module rr_picker #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt,
   output logic          any
);

   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      any = 1'b0;
      for (int i = N; i >= 1; i--) begin
         j = (int'(ptr) + i) % N;
         if (req[j]) begin
            gnt = IW'(j);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: holds a grant from sop to eop,
// registers the egress beat, flags protocol errors and closes stalled
// packets with a synthetic bad eop beat.
module pkt_rr_arbiter
   import pkt_arb_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int DATA_WIDTH     = 64,
   parameter int PLEN_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                             iclk,
   input  logic                             irst_n,
   input  logic [NUM_PORTS-1:0]             ivalid,
   input  logic [NUM_PORTS-1:0]             isop,
   input  logic [NUM_PORTS-1:0]             ieop,
   input  logic [NUM_PORTS-1:0]             ibad,
   input  logic [NUM_PORTS-1:0]             ihalf_word_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  idata,
   input  logic [NUM_PORTS*PLEN_WIDTH-1:0]  iplen,
   output logic [NUM_PORTS-1:0]             iready,
   output logic                             ovalid,
   output logic                             osop,
   output logic                             oeop,
   output logic                             obad,
   output logic                             ohalf_word_valid,
   output logic [DATA_WIDTH-1:0]            odata,
   output logic [PLEN_WIDTH-1:0]            oplen,
   output logic [$clog2(NUM_PORTS)-1:0]     oport_id,
   input  logic                             oready,
   output logic [2:0]                       oerr_status,
   output logic                             ocpu_interrupt
);

   localparam int IW  = $clog2(NUM_PORTS);
   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0]  PTR_RST = IW'(NUM_PORTS - 1);
   localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES - 1);

   state_t         state, nxt_state;
   logic [IW-1:0]  g, ptr, pick;
   logic           any, first, acc, load;
   logic [WDW-1:0] wd;
   beat_t          eg, cur, ld_beat;
   logic           eg_vld;
   logic [IW-1:0]  eg_port;
   logic [2:0]     err, err_set;

   rr_picker #(.N(NUM_PORTS)) u_pick (
      .req (ivalid),
      .ptr (ptr),
      .gnt (pick),
      .any (any)
   );

   // Next state, per-port ready, egress load and error pulses.
   always_comb begin
      acc       = ~eg_vld | oready;
      nxt_state = state;
      iready    = '0;
      load      = 1'b0;
      ld_beat   = '0;
      err_set   = '0;
      cur                 = '0;
      cur.sop             = isop[g];
      cur.eop             = ieop[g];
      cur.bad             = ibad[g];
      cur.half_word_valid = ihalf_word_valid[g];
      cur.plen            = iplen[int'(g)*PLEN_WIDTH +: PLEN_WIDTH];
      cur.data            = idata[int'(g)*DATA_WIDTH +: DATA_WIDTH];
      case (state)
         IDLE: if (any) nxt_state = PKT;
         PKT: begin
            iready[g] = acc;
            if (ivalid[g] && acc) begin
               if (first && !isop[g]) begin
                  // Headless packet: swallow it rather than forward garbage.
                  err_set[ERR_NO_SOP] = 1'b1;
                  nxt_state = ieop[g] ? IDLE : DROP;
               end else begin
                  load        = 1'b1;
                  ld_beat     = cur;
                  ld_beat.sop = isop[g] & first;
                  if (!first && isop[g]) err_set[ERR_MID_SOP] = 1'b1;
                  if (ieop[g]) nxt_state = IDLE;
               end
            end else if (!ivalid[g] && wd == WD_MAX) begin
               err_set[ERR_TIMEOUT] = 1'b1;
               nxt_state = ABORT;
            end
         end
         DROP: begin
            iready[g] = 1'b1;
            if (ivalid[g] && ieop[g]) nxt_state = IDLE;
         end
         ABORT: begin
            if (acc) begin
               // Close the egress packet so downstream never sees it hang.
               load        = 1'b1;
               ld_beat.eop = 1'b1;
               ld_beat.bad = 1'b1;
               nxt_state   = DROP;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) state <= IDLE;
      else         state <= nxt_state;
   end

   // Grant, round-robin pointer and first-beat tracking.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         g     <= '0;
         ptr   <= PTR_RST;
         first <= 1'b0;
      end else if (state == IDLE && any) begin
         g     <= pick;
         ptr   <= pick;
         first <= 1'b1;
      end else if (state == PKT && ivalid[g] && acc) begin
         first <= 1'b0;
      end
   end

   // Stall watchdog: counts idle cycles of the granted port mid-packet.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n)                   wd <= '0;
      else if (state != PKT)         wd <= '0;
      else if (ivalid[g] && acc)     wd <= '0;
      else if (!ivalid[g])           wd <= wd + 1'b1;
   end

   // Egress register: loads on forward, empties when drained.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         eg      <= '0;
         eg_vld  <= 1'b0;
         eg_port <= '0;
      end else if (load) begin
         eg      <= ld_beat;
         eg_vld  <= 1'b1;
         eg_port <= g;
      end else if (acc) begin
         eg_vld  <= 1'b0;
      end
   end

   // Sticky error bits.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) err <= '0;
      else         err <= err | err_set;
   end

   assign ovalid           = eg_vld;
   assign osop             = eg.sop;
   assign oeop             = eg.eop;
   assign obad             = eg.bad;
   assign ohalf_word_valid = eg.half_word_valid;
   assign odata            = eg.data;
   assign oplen            = eg.plen;
   assign oport_id         = eg_port;
   assign oerr_status      = err;
   assign ocpu_interrupt   = |err;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard bench for pkt_rr_arbiter: per-port source queues feed the
// ingress, expected egress beats are queued as stimulus is built.
module tb_pkt_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int PW = 14;

   typedef struct {
      bit            vld;
      bit            sop, eop, bad, hwv;
      logic [DW-1:0] data;
      logic [PW-1:0] plen;
   } item_t;

   typedef struct {
      logic          sop, eop, bad, hwv;
      logic [DW-1:0] data;
      logic [PW-1:0] plen;
      logic [1:0]    port;
   } exp_t;

   logic             iclk = 1'b0;
   logic             irst_n;
   logic [NP-1:0]    ivalid, isop, ieop, ibad, ihwv;
   logic [NP*DW-1:0] idata;
   logic [NP*PW-1:0] iplen;
   logic [NP-1:0]    iready;
   logic             ovalid, osop, oeop, obad, ohwv;
   logic [DW-1:0]    odata;
   logic [PW-1:0]    oplen;
   logic [1:0]       oport_id;
   logic             oready;
   logic [2:0]       oerr_status;
   logic             ocpu_interrupt;

   pkt_rr_arbiter #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .TIMEOUT_CYCLES(16)
   ) dut (
      .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isop(isop), .ieop(ieop),
      .ibad(ibad), .ihalf_word_valid(ihwv), .idata(idata), .iplen(iplen),
      .iready(iready), .ovalid(ovalid), .osop(osop), .oeop(oeop), .obad(obad),
      .ohalf_word_valid(ohwv), .odata(odata), .oplen(oplen), .oport_id(oport_id),
      .oready(oready), .oerr_status(oerr_status), .ocpu_interrupt(ocpu_interrupt)
   );

   always #5 iclk = ~iclk;

   item_t         src_q[NP][$];
   exp_t          exp_q[$];
   int            sop_q[$];
   int            n_cmp = 0, n_bad = 0;
   int            cyc = 0;
   int            rdy_mode = 0;
   bit            sb_en = 1'b1;
   bit            hold = 1'b0;
   logic [DW-1:0] held_data;

   task automatic push_beat(input int p, input bit vld, input bit sop, input bit eop,
                            input bit bad, input bit hwv, input logic [PW-1:0] plen,
                            input bit want, input bit exp_sop);
      item_t it;
      exp_t  e;
      it.vld = vld; it.sop = sop; it.eop = eop; it.bad = bad; it.hwv = hwv;
      it.data = {$urandom, $urandom}; it.plen = plen;
      src_q[p].push_back(it);
      if (vld && want) begin
         e.sop = exp_sop; e.eop = eop; e.bad = bad; e.hwv = hwv;
         e.data = it.data; e.plen = plen; e.port = 2'(p);
         exp_q.push_back(e);
      end
   endtask

   task automatic add_pkt(input int p, input int n, input bit want);
      logic [PW-1:0] plen;
      bit bad;
      plen = PW'($urandom_range(1, 16383));
      bad  = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++)
         push_beat(p, 1, b == 0, b == n - 1, bad, (b == n - 1) && plen[0], plen, want, b == 0);
   endtask

   task automatic add_idle(input int p, input int n);
      for (int i = 0; i < n; i++) push_beat(p, 0, 0, 0, 0, 0, '0, 0, 0);
   endtask

   // One cycle: drive at negedge, sample after settling, retire transfers.
   task automatic step();
      exp_t e;
      @(negedge iclk);
      case (rdy_mode)
         0:       oready = 1'b1;
         1:       oready = ~oready;
         default: oready = 1'($urandom_range(0, 1));
      endcase
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0 && src_q[p][0].vld) begin
            ivalid[p] = 1'b1; isop[p] = src_q[p][0].sop; ieop[p] = src_q[p][0].eop;
            ibad[p] = src_q[p][0].bad; ihwv[p] = src_q[p][0].hwv;
            idata[p*DW +: DW] = src_q[p][0].data; iplen[p*PW +: PW] = src_q[p][0].plen;
         end else begin
            ivalid[p] = 1'b0; isop[p] = 1'b0; ieop[p] = 1'b0; ibad[p] = 1'b0; ihwv[p] = 1'b0;
         end
      end
      #1;
      if (sb_en) begin
         if (hold) begin
            n_cmp++;
            if (ovalid !== 1'b1 || odata !== held_data) begin
               n_bad++;
               $display("FAIL hold_stable: got vld=%b data=%h, want vld=1 data=%h", ovalid, odata, held_data);
            end
         end
         if (ovalid && oready) begin
            n_cmp++;
            if (osop) sop_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_beat: got port=%0d data=%h eop=%b, want no beat", oport_id, odata, oeop);
            end else begin
               e = exp_q.pop_front();
               if (osop !== e.sop || oeop !== e.eop || obad !== e.bad || ohwv !== e.hwv ||
                   odata !== e.data || oplen !== e.plen || oport_id !== e.port) begin
                  n_bad++;
                  $display("FAIL egress_beat: got s%b e%b b%b h%b p%0d d=%h l=%0d, want s%b e%b b%b h%b p%0d d=%h l=%0d",
                           osop, oeop, obad, ohwv, oport_id, odata, oplen,
                           e.sop, e.eop, e.bad, e.hwv, e.port, e.data, e.plen);
               end
            end
         end
         hold = ovalid && !oready;
         held_data = odata;
      end
      for (int p = 0; p < NP; p++)
         if (src_q[p].size() > 0 && (!src_q[p][0].vld || (ivalid[p] && iready[p])))
            void'(src_q[p].pop_front());
      cyc++;
   endtask

   task automatic clear_q();
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_q.delete();
      sop_q.delete();
   endtask

   task automatic run(input int budget);
      int  n;
      bit  busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < budget) begin
         step();
         n++;
         busy = exp_q.size() > 0;
         for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) busy = 1'b1;
      end
      if (busy) begin
         n_cmp++; n_bad++;
         $display("FAIL run_timeout: got %0d expected beats left after %0d cycles, want 0", exp_q.size(), n);
         clear_q();
      end
      repeat (3) step();
   endtask

   task automatic do_reset();
      @(negedge iclk);
      irst_n = 1'b0;
      ivalid = '0; isop = '0; ieop = '0; ibad = '0; ihwv = '0;
      oready = 1'b1; rdy_mode = 0; sb_en = 1'b1; hold = 1'b0;
      clear_q();
      @(negedge iclk);
      irst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge iclk);
      irst_n = 1'b0;
      ivalid = '1;
      #1;
      n_cmp++;
      if ({ovalid, osop, oeop, obad, ohwv, oport_id, oerr_status, ocpu_interrupt} !== '0 ||
          odata !== '0 || oplen !== '0 || iready !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got vld=%b rdy=%b err=%b data=%h, want all zero", ovalid, iready, oerr_status, odata);
      end
      do_reset();
   endtask

   task automatic test_two_ports();
      int c0;
      do_reset();
      add_pkt(0, 3, 1);
      add_pkt(2, 3, 1);
      c0 = cyc;
      run(40);
      n_cmp++;
      if (sop_q.size() != 2 || sop_q[0] != c0 + 2 || sop_q[1] != c0 + 6) begin
         n_bad++;
         $display("FAIL sop_timing: got %0d sops first=%0d second=%0d, want 2 at %0d and %0d",
                  sop_q.size(), sop_q.size() > 0 ? sop_q[0] - c0 : -1,
                  sop_q.size() > 1 ? sop_q[1] - c0 : -1, 2, 6);
      end
   endtask

   task automatic test_rr_order();
      do_reset();
      rdy_mode = 2;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++) add_pkt(p, $urandom_range(1, 4), 1);
      run(200);
   endtask

   task automatic test_back_to_back();
      do_reset();
      rdy_mode = 1;
      add_pkt(1, 4, 1);
      add_pkt(1, 2, 1);
      run(60);
   endtask

   task automatic test_no_sop();
      do_reset();
      push_beat(1, 1, 0, 0, 0, 0, 14'd64, 0, 0);
      push_beat(1, 1, 0, 0, 0, 0, 14'd64, 0, 0);
      push_beat(1, 1, 0, 1, 0, 0, 14'd64, 0, 0);
      add_idle(2, 8);
      add_pkt(2, 2, 1);
      run(60);
      n_cmp++;
      if (oerr_status !== 3'b001 || ocpu_interrupt !== 1'b1) begin
         n_bad++;
         $display("FAIL no_sop_err: got err=%b irq=%b, want err=001 irq=1", oerr_status, ocpu_interrupt);
      end
   endtask

   task automatic test_mid_sop();
      do_reset();
      push_beat(2, 1, 1, 0, 0, 0, 14'd24, 1, 1);
      push_beat(2, 1, 1, 0, 0, 0, 14'd24, 1, 0);
      push_beat(2, 1, 0, 1, 0, 1, 14'd24, 1, 0);
      run(40);
      n_cmp++;
      if (oerr_status !== 3'b010) begin
         n_bad++;
         $display("FAIL mid_sop_err: got err=%b, want 010", oerr_status);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      do_reset();
      push_beat(3, 1, 1, 0, 0, 0, 14'd100, 1, 1);
      e.sop = 0; e.eop = 1; e.bad = 1; e.hwv = 0; e.data = '0; e.plen = '0; e.port = 2'd3;
      exp_q.push_back(e);
      add_idle(3, 20);
      push_beat(3, 1, 0, 0, 0, 0, 14'd100, 0, 0);
      push_beat(3, 1, 0, 1, 0, 0, 14'd100, 0, 0);
      add_idle(0, 30);
      add_pkt(0, 2, 1);
      run(120);
      n_cmp++;
      if (oerr_status !== 3'b100 || ocpu_interrupt !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_err: got err=%b irq=%b, want err=100 irq=1", oerr_status, ocpu_interrupt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      sb_en = 1'b0;
      add_pkt(2, 8, 0);
      repeat (4) step();
      @(posedge iclk);
      #2;
      irst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ovalid, osop, oeop, obad, ohwv, oport_id, oerr_status, ocpu_interrupt} !== '0 ||
          odata !== '0 || oplen !== '0 || iready !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got vld=%b rdy=%b port=%0d data=%h, want all zero", ovalid, iready, oport_id, odata);
      end
      clear_q();
      ivalid = '0; isop = '0; ieop = '0;
      @(negedge iclk);
      irst_n = 1'b1;
      sb_en = 1'b1; hold = 1'b0;
      add_pkt(0, 2, 1);
      add_pkt(3, 2, 1);
      run(40);
   endtask

   initial begin
      irst_n = 1'b0;
      ivalid = '0; isop = '0; ieop = '0; ibad = '0; ihwv = '0;
      idata = '0; iplen = '0; oready = 1'b1;
      test_reset();
      test_two_ports();
      test_rr_order();
      test_back_to_back();
      test_no_sop();
      test_mid_sop();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
